// File: rtl/red_pitaya_bus_sequencer.sv
// Command-queued bus master: buffers read/write commands in a FIFO and plays them one at a
// time onto the sys_* bus, returning one response each. Define BUS_SEQ_TIMEOUT_EN to abort stalled waits.
module red_pitaya_bus_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic [3:0]  sys_sel,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack,
    output logic        busy_o,
    output logic [4:0]  level_o
);

    // state    | meaning
    // ST_IDLE  | waiting for a queued command; pops the FIFO head when one is present
    // ST_ISSUE | one-cycle sys_wen/sys_ren strobe
    // ST_WAIT  | holding address/data until the responder acks or errors
    // ST_RESP  | response presented until rsp_ready_i

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [4:0] FULL_LEVEL = 5'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [64:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [4:0]    level_q;
    logic          ready_en_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic [64:0]   head;
    logic          op_we_q;

    assign fifo_full   = (level_q == FULL_LEVEL);
    assign fifo_empty  = (level_q == 5'd0);
    // ready_en_q keeps the queue closed until the first clock after reset release
    assign cmd_ready_o = ready_en_q & ~fifo_full;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign head        = fifo_mem[rd_ptr_q];
    assign level_o     = level_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_we_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 5'd0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 5'd1;
                2'b01:   level_q <= level_q - 5'd1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef BUS_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt_q;
    logic        to_hit;
    logic        rsp_timeout_q;

    // Down-counter loaded during ISSUE; terminal count in WAIT means TIMEOUT cycles elapsed
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q      <= 16'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE) begin
                to_cnt_q <= TO_LOAD;
            end else if (state_q == ST_WAIT && to_cnt_q != 16'd0) begin
                to_cnt_q <= to_cnt_q - 16'd1;
            end
            if (capture) begin
                rsp_timeout_q <= 1'b0;
            end else if (to_hit) begin
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout_o = rsp_timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
`ifdef BUS_SEQ_TIMEOUT_EN
        to_hit  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sys_ack || sys_err) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef BUS_SEQ_TIMEOUT_EN
                else if (to_cnt_q == 16'd0) begin
                    to_hit  = 1'b1;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation and response registers; address/data hold from the pop until the next pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_we_q     <= 1'b0;
            sys_addr    <= 32'd0;
            sys_wdata   <= 32'd0;
            sys_sel     <= 4'h0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (pop) begin
                op_we_q   <= head[64];
                sys_addr  <= head[63:32];
                sys_wdata <= head[31:0];
                sys_sel   <= head[64] ? 4'hF : 4'h0;
            end
            if (capture) begin
                rsp_rdata_o <= op_we_q ? 32'd0 : sys_rdata;
                rsp_err_o   <= sys_err;
            end
`ifdef BUS_SEQ_TIMEOUT_EN
            if (to_hit) begin
                rsp_rdata_o <= 32'd0;
                rsp_err_o   <= 1'b0;
            end
`endif
        end
    end

    assign sys_wen     = (state_q == ST_ISSUE) &  op_we_q;
    assign sys_ren     = (state_q == ST_ISSUE) & ~op_we_q;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_red_pitaya_bus_sequencer.sv
// Directed bench for red_pitaya_bus_sequencer (DEPTH=4, TIMEOUT=10); honours BUS_SEQ_TIMEOUT_EN.
module tb_red_pitaya_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;
    logic        busy;
    logic [4:0]  level;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    logic [31:0] exp_addr  [4];
    logic [31:0] exp_wdata [4];
    logic        exp_we    [4];

    always #5 clk = ~clk;

    red_pitaya_bus_sequencer #(
        .DEPTH  (4),
        .TIMEOUT(10)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .sys_addr     (sys_addr),
        .sys_wdata    (sys_wdata),
        .sys_sel      (sys_sel),
        .sys_wen      (sys_wen),
        .sys_ren      (sys_ren),
        .sys_rdata    (sys_rdata),
        .sys_err      (sys_err),
        .sys_ack      (sys_ack),
        .busy_o       (busy),
        .level_o      (level)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        sys_rdata = 32'd0;
        sys_err   = 1'b0;
        sys_ack   = 1'b0;

        exp_addr[0] = 32'h0000_0200; exp_wdata[0] = 32'h0000_000B; exp_we[0] = 1'b1;
        exp_addr[1] = 32'h0000_0300; exp_wdata[1] = 32'h0000_00C0; exp_we[1] = 1'b0;
        exp_addr[2] = 32'h0000_0400; exp_wdata[2] = 32'h0000_000D; exp_we[2] = 1'b1;
        exp_addr[3] = 32'h0000_0500; exp_wdata[3] = 32'h0000_00E0; exp_we[3] = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", {30'd0, sys_wen, sys_ren}, 32'd0);
        chk("rst_addr", sys_addr, 32'd0);
        chk("rst_sel", 32'(sys_sel), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // single write, ack one cycle after strobe
        drive_cmd(1'b1, 32'h4030_0004, 32'h0000_0003);
        tick();
        cmd_valid = 1'b0;
        chk("wr_level_after_push", 32'(level), 32'd1);
        chk("wr_no_early_strobe", 32'(sys_wen), 32'd0);
        tick();
        chk("wr_strobe", {30'd0, sys_wen, sys_ren}, 32'd2);
        chk("wr_sel", 32'(sys_sel), 32'hF);
        chk("wr_addr", sys_addr, 32'h4030_0004);
        chk("wr_wdata", sys_wdata, 32'h0000_0003);
        tick();
        chk("wr_strobe_one_cycle", {30'd0, sys_wen, sys_ren}, 32'd0);
        chk("wr_wait_addr_hold", sys_addr, 32'h4030_0004);
        chk("wr_wait_busy", 32'(busy), 32'd1);
        sys_ack = 1'b1;
        tick();
        sys_ack = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
        tick();
        chk("wr_rsp_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("wr_rsp_done", 32'(rsp_valid), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);

        // read; an ack during ISSUE must be ignored
        drive_cmd(1'b0, 32'h4030_000C, 32'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rd_strobe", {30'd0, sys_wen, sys_ren}, 32'd1);
        chk("rd_sel", 32'(sys_sel), 32'h0);
        sys_ack   = 1'b1;
        sys_rdata = 32'hDEAD_BEEF;
        tick();
        sys_ack   = 1'b0;
        chk("rd_issue_ack_ignored", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_still_waiting", 32'(rsp_valid), 32'd0);
        sys_ack   = 1'b1;
        sys_rdata = 32'h0000_00FF;
        tick();
        sys_ack   = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h0000_00FF);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // fill the FIFO behind a stalled read
        drive_cmd(1'b0, 32'h0000_0100, 32'd0);
        tick();
        drive_cmd(exp_we[0], exp_addr[0], exp_wdata[0]);
        tick();
        chk("fifo_push_pop_level", 32'(level), 32'd1);
        drive_cmd(exp_we[1], exp_addr[1], exp_wdata[1]);
        tick();
        chk("fifo_level2", 32'(level), 32'd2);
        drive_cmd(exp_we[2], exp_addr[2], exp_wdata[2]);
        tick();
        drive_cmd(exp_we[3], exp_addr[3], exp_wdata[3]);
        tick();
        chk("fifo_full_level", 32'(level), 32'd4);
        chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
        drive_cmd(1'b1, 32'h0000_0600, 32'h0000_00F0);
        tick();
        cmd_valid = 1'b0;
        chk("fifo_reject_level", 32'(level), 32'd4);
        sys_rdata = 32'h0000_A5A5;
        sys_ack   = 1'b1;
        tick();
        sys_ack   = 1'b0;
        chk("fifo_head_rdata", rsp_rdata, 32'h0000_A5A5);
        tick();
        chk("fifo_idle_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("fifo_pop_level", 32'(level), 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("order_addr", sys_addr, exp_addr[i]);
            chk("order_wdata", sys_wdata, exp_wdata[i]);
            chk("order_strobe", {30'd0, sys_wen, sys_ren}, exp_we[i] ? 32'd2 : 32'd1);
            sys_rdata = 32'h0000_1000 + 32'(i);
            sys_ack   = 1'b1;
            tick();
            tick();
            sys_ack = 1'b0;
            chk("order_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("order_rsp_rdata", rsp_rdata, exp_we[i] ? 32'd0 : 32'h0000_1000 + 32'(i));
            tick();
            chk("order_gap_idle", {30'd0, sys_wen, sys_ren}, 32'd0);
            tick();
        end
        chk("drained_level", 32'(level), 32'd0);
        chk("drained_busy", 32'(busy), 32'd0);

        // ack together with err on a read
        drive_cmd(1'b0, 32'h0000_1234, 32'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        sys_ack   = 1'b1;
        sys_err   = 1'b1;
        sys_rdata = 32'h0000_1234;
        tick();
        sys_ack = 1'b0;
        sys_err = 1'b0;
        chk("ackerr_rdata", rsp_rdata, 32'h0000_1234);
        chk("ackerr_err", 32'(rsp_err), 32'd1);
        tick();

        // err alone on a write: data forced to zero
        drive_cmd(1'b1, 32'h4030_0010, 32'h0000_0055);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        sys_err   = 1'b1;
        sys_rdata = 32'h0000_FFFF;
        tick();
        sys_err = 1'b0;
        chk("werr_rdata", rsp_rdata, 32'd0);
        chk("werr_err", 32'(rsp_err), 32'd1);
        tick();

        // no responder: timeout or indefinite wait
        drive_cmd(1'b0, 32'h0000_0700, 32'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
`ifdef BUS_SEQ_TIMEOUT_EN
        repeat (9) tick();
        chk("to_not_yet", 32'(rsp_valid), 32'd0);
        tick();
        chk("to_valid", 32'(rsp_valid), 32'd1);
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_err", 32'(rsp_err), 32'd0);
        chk("to_rdata", rsp_rdata, 32'd0);
        tick();
        drive_cmd(1'b0, 32'h0000_0780, 32'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
`else
        repeat (1000) tick();
        chk("hang_busy", 32'(busy), 32'd1);
        chk("hang_no_rsp", 32'(rsp_valid), 32'd0);
        chk("hang_timeout_tied", 32'(rsp_timeout), 32'd0);
`endif

        // reset while in WAIT with a queued command
        drive_cmd(1'b1, 32'h0000_0800, 32'h0000_0008);
        tick();
        cmd_valid = 1'b0;
        chk("abort_pre_level", 32'(level), 32'd1);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_strobes", {30'd0, sys_wen, sys_ren}, 32'd0);
        chk("abort_level", 32'(level), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        chk("abort_addr", sys_addr, 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("release_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("release_ready_high", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("release_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
